// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle between IF/ID and the immediate generator's ID/EX side.
// Optional err_o lane exists only when IMM_ERR_EN is defined.
interface imm_gen_pipe_if #(
  parameter int unsigned XLEN = 32
);

  logic            flush_i;
  logic            valid_i;
  logic            ready_o;
  logic [31:0]     instr_i;
  logic            valid_o;
  logic            ready_i;
  logic [XLEN-1:0] imm_o;
  logic [2:0]      fmt_o;
`ifdef IMM_ERR_EN
  logic            err_o;
`endif

`ifdef IMM_ERR_EN
  // Design-side view
  modport slave (
    input  flush_i, valid_i, instr_i, ready_i,
    output ready_o, valid_o, imm_o, fmt_o, err_o
  );

  // Environment-side view
  modport master (
    output flush_i, valid_i, instr_i, ready_i,
    input  ready_o, valid_o, imm_o, fmt_o, err_o
  );
`else
  // Design-side view
  modport slave (
    input  flush_i, valid_i, instr_i, ready_i,
    output ready_o, valid_o, imm_o, fmt_o
  );

  // Environment-side view
  modport master (
    output flush_i, valid_i, instr_i, ready_i,
    input  ready_o, valid_o, imm_o, fmt_o
  );
`endif

endinterface

// File: rtl/imm_gen_pipe.sv
// Registered RISC-V immediate generator for the ID stage, fronted by a
// 2-entry skid buffer. Optional feature macro: IMM_ERR_EN (adds err_o).
module imm_gen_pipe #(
  parameter int unsigned XLEN = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  imm_gen_pipe_if.slave  bus
);

  localparam int unsigned FMT_W = 3;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
`ifdef IMM_ERR_EN
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
`endif

  localparam logic [FMT_W-1:0] FMT_NONE = 3'd0;
  localparam logic [FMT_W-1:0] FMT_I    = 3'd1;
  localparam logic [FMT_W-1:0] FMT_SH   = 3'd2;
  localparam logic [FMT_W-1:0] FMT_S    = 3'd3;
  localparam logic [FMT_W-1:0] FMT_B    = 3'd4;
  localparam logic [FMT_W-1:0] FMT_U    = 3'd5;
  localparam logic [FMT_W-1:0] FMT_J    = 3'd6;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [FMT_W-1:0] fmt;
`ifdef IMM_ERR_EN
    logic             err;
`endif
  } entry_t;

  // Buffer occupancy: the state is the entry count
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;
  entry_t head_q, second_q;
  entry_t dec_c;

  logic [6:0] op_c;
  logic [2:0] f3_c;
  logic [5:0] shamt_c;
  logic       ready_c;
  logic       valid_c;
  logic       push_c;
  logic       pop_c;
  logic       load_head_new_c;
  logic       load_second_new_c;
  logic       head_from_second_c;

  assign op_c = bus.instr_i[6:0];
  assign f3_c = bus.instr_i[14:12];

  // RV64 shifts carry a 6-bit shamt; RV32 only uses the low 5 bits
  assign shamt_c = (XLEN == 64) ? bus.instr_i[25:20] : {1'b0, bus.instr_i[24:20]};

  // Immediate decode of the incoming instruction word
  always_comb begin
    dec_c = '0;
    case (op_c)
      OP_IMM: begin
        if ((f3_c == 3'b001) || (f3_c == 3'b101)) begin
          dec_c.imm = XLEN'(shamt_c);
          dec_c.fmt = FMT_SH;
`ifdef IMM_ERR_EN
          dec_c.err = (XLEN == 32) && bus.instr_i[25];
`endif
        end else begin
          dec_c.imm = XLEN'($signed(bus.instr_i[31:20]));
          dec_c.fmt = FMT_I;
        end
      end
      OP_LOAD, OP_JALR: begin
        dec_c.imm = XLEN'($signed(bus.instr_i[31:20]));
        dec_c.fmt = FMT_I;
      end
      OP_STORE: begin
        dec_c.imm = XLEN'($signed({bus.instr_i[31:25], bus.instr_i[11:7]}));
        dec_c.fmt = FMT_S;
      end
      OP_BRANCH: begin
        dec_c.imm = XLEN'($signed({bus.instr_i[31], bus.instr_i[7],
                                   bus.instr_i[30:25], bus.instr_i[11:8], 1'b0}));
        dec_c.fmt = FMT_B;
      end
      OP_LUI, OP_AUIPC: begin
        dec_c.imm = XLEN'($signed({bus.instr_i[31:12], 12'b0}));
        dec_c.fmt = FMT_U;
      end
      OP_JAL: begin
        dec_c.imm = XLEN'($signed({bus.instr_i[31], bus.instr_i[19:12],
                                   bus.instr_i[20], bus.instr_i[30:21], 1'b0}));
        dec_c.fmt = FMT_J;
      end
`ifdef IMM_ERR_EN
      OP_REG, OP_FENCE, OP_SYSTEM: begin
        dec_c.err = 1'b0;
      end
      default: begin
        dec_c.err = 1'b1;
      end
`else
      default: begin
        dec_c.fmt = FMT_NONE;
      end
`endif
    endcase
  end

  // Handshake qualifiers derive from registered state only
  assign ready_c = (state_q != ST_FULL);
  assign valid_c = (state_q != ST_EMPTY);
  assign push_c  = bus.valid_i && ready_c;
  assign pop_c   = valid_c && bus.ready_i;

  // Occupancy register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next occupancy and entry-movement strobes; flush beats push and pop
  always_comb begin
    state_d            = state_q;
    load_head_new_c    = 1'b0;
    load_second_new_c  = 1'b0;
    head_from_second_c = 1'b0;
    if (bus.flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push_c) begin
            state_d         = ST_ONE;
            load_head_new_c = 1'b1;
          end
        end
        ST_ONE: begin
          case ({push_c, pop_c})
            2'b10: begin
              state_d           = ST_FULL;
              load_second_new_c = 1'b1;
            end
            2'b01: begin
              state_d = ST_EMPTY;
            end
            2'b11: begin
              state_d         = ST_ONE;
              load_head_new_c = 1'b1;
            end
            default: begin
              state_d = ST_ONE;
            end
          endcase
        end
        ST_FULL: begin
          if (pop_c) begin
            state_d            = ST_ONE;
            head_from_second_c = 1'b1;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // Entry storage; the head register drives the outputs directly
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      head_q   <= '0;
      second_q <= '0;
    end else begin
      if (load_head_new_c) begin
        head_q <= dec_c;
      end else if (head_from_second_c) begin
        head_q <= second_q;
      end
      if (load_second_new_c) begin
        second_q <= dec_c;
      end
    end
  end

  assign bus.ready_o = ready_c;
  assign bus.valid_o = valid_c;
  assign bus.imm_o   = head_q.imm;
  assign bus.fmt_o   = head_q.fmt;
`ifdef IMM_ERR_EN
  assign bus.err_o   = head_q.err;
`endif

endmodule
